// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants and transmitter FSM encoding shared by the UART blocks
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  typedef logic [2:0] tx_state_t;
  localparam tx_state_t S_IDLE = 3'd0;
  localparam tx_state_t S_START = 3'd1;
  localparam tx_state_t S_DATA = 3'd2;
  localparam tx_state_t S_PAR = 3'd3;
  localparam tx_state_t S_STOP = 3'd4;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word fall-through synchronous FIFO with registered occupancy count
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      cnt,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter serialising words from an internal FIFO
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 2500,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_vld,
  output logic                        tx_rdy,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);
  localparam int BW = $clog2(CLK_DIV);
  localparam int NB = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [NB-1:0] DATA_LAST = NB'(DATA_BITS - 1);
  localparam logic [NB-1:0] STOP_LAST = NB'(STOP_BITS - 1);
  tx_state_t state;
  logic [BW-1:0] baud_cnt;
  logic [NB-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg, fifo_dout;
  logic par_bit, full, empty, pop, baud_wrap;
  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_vld),
    .pop   (pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt),
    .full  (full),
    .empty (empty)
  );
  assign tx_rdy = !full;
  assign busy = state != S_IDLE || !empty;
  assign baud_wrap = baud_cnt == BAUD_LAST;
  // popping at the last stop-bit wrap chains frames with no idle gap
  assign pop = !empty && (state == S_IDLE || (state == S_STOP && baud_wrap && bit_cnt == STOP_LAST));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par_bit <= 1'b0;
      tx <= 1'b1;
    end else if (pop) begin
      state <= S_START;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shreg <= fifo_dout;
      par_bit <= (PARITY == PAR_EVEN) ? ^fifo_dout : ~^fifo_dout;
      tx <= 1'b0;
    end else if (state != S_IDLE) begin
      baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
      if (baud_wrap) begin
        if (state == S_START) begin
          state <= S_DATA;
          tx <= shreg[0];
        end else if (state == S_DATA && bit_cnt != DATA_LAST) begin
          bit_cnt <= bit_cnt + 1'b1;
          shreg <= shreg >> 1;
          tx <= shreg[1];
        end else if (state == S_DATA && PARITY != PAR_NONE) begin
          state <= S_PAR;
          bit_cnt <= '0;
          tx <= par_bit;
        end else if (state == S_DATA || state == S_PAR) begin
          state <= S_STOP;
          bit_cnt <= '0;
          tx <= 1'b1;
        end else if (bit_cnt != STOP_LAST) begin
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          state <= S_IDLE;
        end
      end
    end
endmodule
